// File: rtl/stage_id.sv
// -----------------------------------------------------------------------------
// stage_id : RV32I instruction decode stage.
//
// Buffers one instruction from IF, decodes its immediate and register fields,
// holds it while a source register is busy, offers it to EX with a valid/ready
// handshake, and resolves branches/jumps into a one-cycle redirect to IF.
//
// Ports
//   clk, rst                 core clock, asynchronous active-low reset
//   IR_I, PC_I, Done_I       instruction, its PC and valid flag from IF
//   Stall_O                  hold IF in its done state
//   RF_raddr1/2, RF_rdata1/2 register file read port (data is combinational)
//   Busy_Mask                per-register pending-write mask (bit 0 ignored)
//   Valid_O, Ready_I         issue handshake with EX
//   PC_O, Imm_O, Op1_O/Op2_O instruction PC, immediate, source operands
//   Opcode_O, Funct3_O,
//   Funct7b5_O, Rd_O         decoded fields
//   next_PC, Feedback_Branch redirect target and one-cycle redirect pulse
// -----------------------------------------------------------------------------
module stage_id (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_I,
    input  logic [31:0] PC_I,
    input  logic        Done_I,
    output logic        Stall_O,
    output logic [4:0]  RF_raddr1,
    output logic [4:0]  RF_raddr2,
    input  logic [31:0] RF_rdata1,
    input  logic [31:0] RF_rdata2,
    input  logic [31:0] Busy_Mask,
    output logic        Valid_O,
    input  logic        Ready_I,
    output logic [31:0] PC_O,
    output logic [31:0] Imm_O,
    output logic [31:0] Op1_O,
    output logic [31:0] Op2_O,
    output logic [6:0]  Opcode_O,
    output logic [2:0]  Funct3_O,
    output logic        Funct7b5_O,
    output logic [4:0]  Rd_O,
    output logic [31:0] next_PC,
    output logic        Feedback_Branch
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   next_pc_q, next_pc_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rs1, rs2, rd_field;
    logic [XLEN-1:0]   imm;
    logic              rd_wr, use_rs1, use_rs2;
    logic              is_branch, is_jal, is_jalr, is_ctrl;
    logic              hazard, valid, issue, accept;
    logic              br_eq, br_lt, br_ltu, br_cond, taken;
    logic [XLEN-1:0]   target;

    // Raw fields of the buffered instruction
    assign opcode   = ir_q[6:0];
    assign rd_field = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];

    // Immediate format, destination and source usage by opcode
    always_comb begin
        imm       = '0;
        rd_wr     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm   = {ir_q[31:12], 12'b0};
                rd_wr = 1'b1;
            end
            OP_JAL: begin
                imm    = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
                rd_wr  = 1'b1;
                is_jal = 1'b1;
            end
            OP_JALR: begin
                imm     = {{20{ir_q[31]}}, ir_q[31:20]};
                rd_wr   = 1'b1;
                use_rs1 = 1'b1;
                is_jalr = 1'b1;
            end
            OP_LOAD, OP_IMM: begin
                imm     = {{20{ir_q[31]}}, ir_q[31:20]};
                rd_wr   = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                imm     = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm       = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
            end
            OP_REG: begin
                rd_wr   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: begin
                // Unknown opcode: issues as a NOP with no sources and no rd
                imm = '0;
            end
        endcase
    end

    assign is_ctrl = is_branch | is_jal | is_jalr;

    // x0 is never busy, so a nonzero index is required for a hazard
    assign hazard = (use_rs1 && (rs1 != 5'd0) && Busy_Mask[rs1]) ||
                    (use_rs2 && (rs2 != 5'd0) && Busy_Mask[rs2]);

    assign valid  = (state_q == ST_FULL) && !hazard;
    assign issue  = valid && Ready_I;

    // A buffered control instruction blocks capture even in its issue cycle
    assign accept = Done_I && ((state_q == ST_EMPTY) ||
                               ((state_q == ST_FULL) && issue && !is_ctrl));

    // Branch condition evaluation
    assign br_eq  = (RF_rdata1 == RF_rdata2);
    assign br_lt  = ($signed(RF_rdata1) < $signed(RF_rdata2));
    assign br_ltu = (RF_rdata1 < RF_rdata2);

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = !br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = !br_lt;
            3'b110:  br_cond = br_ltu;
            3'b111:  br_cond = !br_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign taken  = is_branch ? br_cond : (is_jal | is_jalr);
    assign target = is_jalr ? ((RF_rdata1 + imm) & ~XLEN'(1)) : (pc_q + imm);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            ir_q      <= '0;
            pc_q      <= '0;
            next_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
        end
    end

    // Next-state and buffer update
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    ir_d    = IR_I;
                    pc_d    = PC_I;
                end
            end
            ST_FULL: begin
                if (issue) begin
                    if (is_ctrl && taken) begin
                        state_d   = ST_REDIR;
                        next_pc_d = target;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        ir_d    = IR_I;
                        pc_d    = PC_I;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            ST_REDIR: begin
                // Whatever IF offers now is wrong-path and is dropped
                state_d = ST_EMPTY;
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Outputs
    assign Valid_O         = valid;
    assign Stall_O         = Done_I && !accept && (state_q != ST_REDIR);
    assign Feedback_Branch = (state_q == ST_REDIR);
    assign next_PC         = next_pc_q;

    assign RF_raddr1  = rs1;
    assign RF_raddr2  = rs2;
    assign PC_O       = pc_q;
    assign Imm_O      = imm;
    assign Op1_O      = RF_rdata1;
    assign Op2_O      = RF_rdata2;
    assign Opcode_O   = opcode;
    assign Funct3_O   = funct3;
    assign Funct7b5_O = ir_q[30];
    assign Rd_O       = rd_wr ? rd_field : 5'd0;

endmodule

// File: tb/tb_stage_id.sv
// -----------------------------------------------------------------------------
// tb_stage_id : self-checking bench for stage_id.
// Directed scenarios followed by a randomized run against an instruction-stream
// reference model (accepted-but-unissued queue plus a pending redirect flag).
// -----------------------------------------------------------------------------
module tb_stage_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR_I, PC_I;
    logic        Done_I;
    logic        Stall_O;
    logic [4:0]  RF_raddr1, RF_raddr2;
    logic [31:0] RF_rdata1, RF_rdata2;
    logic [31:0] Busy_Mask;
    logic        Valid_O;
    logic        Ready_I;
    logic [31:0] PC_O, Imm_O, Op1_O, Op2_O;
    logic [6:0]  Opcode_O;
    logic [2:0]  Funct3_O;
    logic        Funct7b5_O;
    logic [4:0]  Rd_O;
    logic [31:0] next_PC;
    logic        Feedback_Branch;

    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_fails  = 0;

    assign RF_rdata1 = regs[RF_raddr1];
    assign RF_rdata2 = regs[RF_raddr2];

    always #5 clk = ~clk;

    stage_id dut (
        .clk             (clk),
        .rst             (rst),
        .IR_I            (IR_I),
        .PC_I            (PC_I),
        .Done_I          (Done_I),
        .Stall_O         (Stall_O),
        .RF_raddr1       (RF_raddr1),
        .RF_raddr2       (RF_raddr2),
        .RF_rdata1       (RF_rdata1),
        .RF_rdata2       (RF_rdata2),
        .Busy_Mask       (Busy_Mask),
        .Valid_O         (Valid_O),
        .Ready_I         (Ready_I),
        .PC_O            (PC_O),
        .Imm_O           (Imm_O),
        .Op1_O           (Op1_O),
        .Op2_O           (Op2_O),
        .Opcode_O        (Opcode_O),
        .Funct3_O        (Funct3_O),
        .Funct7b5_O      (Funct7b5_O),
        .Rd_O            (Rd_O),
        .next_PC         (next_PC),
        .Feedback_Branch (Feedback_Branch)
    );

    // ---------------- reference model helpers ----------------
    function automatic bit is_op(input logic [31:0] ir, input logic [6:0] op);
        logic [6:0] o;
        o = ir[6:0];
        return o == op;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ir);
        logic [31:0] neg12;
        neg12 = ir[31] ? 32'd4096 : 32'd0;
        if (is_op(ir, 7'h13) || is_op(ir, 7'h03) || is_op(ir, 7'h67))
            return 32'(ir[31:20]) - neg12;
        if (is_op(ir, 7'h23))
            return 32'({ir[31:25], ir[11:7]}) - neg12;
        if (is_op(ir, 7'h63))
            return (ir[31] ? 32'hFFFF_F000 : 32'h0) + (32'(ir[7]) << 11)
                 + (32'(ir[30:25]) << 5) + (32'(ir[11:8]) << 1);
        if (is_op(ir, 7'h6F))
            return (ir[31] ? 32'hFFF0_0000 : 32'h0) + (32'(ir[19:12]) << 12)
                 + (32'(ir[20]) << 11) + (32'(ir[30:21]) << 1);
        if (is_op(ir, 7'h37) || is_op(ir, 7'h17))
            return ir & 32'hFFFF_F000;
        return 32'h0;
    endfunction

    function automatic logic [4:0] m_rd(input logic [31:0] ir);
        if (is_op(ir, 7'h37) || is_op(ir, 7'h17) || is_op(ir, 7'h6F) || is_op(ir, 7'h67) ||
            is_op(ir, 7'h03) || is_op(ir, 7'h13) || is_op(ir, 7'h33))
            return ir[11:7];
        return 5'd0;
    endfunction

    function automatic bit m_uses1(input logic [31:0] ir);
        return is_op(ir, 7'h67) || is_op(ir, 7'h03) || is_op(ir, 7'h13) ||
               is_op(ir, 7'h23) || is_op(ir, 7'h63) || is_op(ir, 7'h33);
    endfunction

    function automatic bit m_uses2(input logic [31:0] ir);
        return is_op(ir, 7'h23) || is_op(ir, 7'h63) || is_op(ir, 7'h33);
    endfunction

    function automatic bit m_hazard(input logic [31:0] ir, input logic [31:0] mask);
        int a, b;
        a = int'(ir[19:15]);
        b = int'(ir[24:20]);
        return (m_uses1(ir) && a != 0 && mask[a]) || (m_uses2(ir) && b != 0 && mask[b]);
    endfunction

    function automatic bit m_ctrl(input logic [31:0] ir);
        return is_op(ir, 7'h63) || is_op(ir, 7'h6F) || is_op(ir, 7'h67);
    endfunction

    function automatic bit m_taken(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        if (is_op(ir, 7'h6F) || is_op(ir, 7'h67)) return 1'b1;
        if (!is_op(ir, 7'h63)) return 1'b0;
        case (ir[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a);
        if (is_op(ir, 7'h67)) return (a + m_imm(ir)) & 32'hFFFF_FFFE;
        return pc + m_imm(ir);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] ir;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        ir = $urandom;
        ir[6:0]   = ops[$urandom_range(0, 8)];
        ir[19:15] = 5'($urandom_range(0, 7));
        ir[24:20] = 5'($urandom_range(0, 7));
        return ir;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; Done_I = 1'b0; Ready_I = 1'b0; Busy_Mask = '0; IR_I = '0; PC_I = '0;
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        tick();
        Done_I = 1'b1; IR_I = 32'h0050_0093;
        #3;
        n_checks++; if (Valid_O !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b want 0", Valid_O); end
        n_checks++; if (Stall_O !== 1'b0) begin n_fails++; $display("FAIL rst_stall: got %b want 0", Stall_O); end
        n_checks++; if (Feedback_Branch !== 1'b0) begin n_fails++; $display("FAIL rst_fb: got %b want 0", Feedback_Branch); end
        n_checks++; if (next_PC !== 32'h0) begin n_fails++; $display("FAIL rst_npc: got %h want 0", next_PC); end
        n_checks++; if (PC_O !== 32'h0 || Imm_O !== 32'h0 || Rd_O !== 5'd0 || Opcode_O !== 7'h0)
            begin n_fails++; $display("FAIL rst_payload: got pc=%h imm=%h rd=%0d op=%h want all 0", PC_O, Imm_O, Rd_O, Opcode_O); end
        Done_I = 1'b0;
    endtask

    task automatic test_addi();
        do_reset();
        tick();
        Done_I = 1'b1; IR_I = 32'h0050_0093; PC_I = 32'h0; Ready_I = 1'b1;
        #3;
        n_checks++; if (Stall_O !== 1'b0) begin n_fails++; $display("FAIL addi_accept_stall: got %b want 0", Stall_O); end
        n_checks++; if (Valid_O !== 1'b0) begin n_fails++; $display("FAIL addi_empty_valid: got %b want 0", Valid_O); end
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Valid_O !== 1'b1) begin n_fails++; $display("FAIL addi_valid: got %b want 1", Valid_O); end
        n_checks++; if (Imm_O !== 32'd5) begin n_fails++; $display("FAIL addi_imm: got %h want 5", Imm_O); end
        n_checks++; if (Rd_O !== 5'd1) begin n_fails++; $display("FAIL addi_rd: got %0d want 1", Rd_O); end
        n_checks++; if (Opcode_O !== 7'h13) begin n_fails++; $display("FAIL addi_opcode: got %h want 13", Opcode_O); end
        n_checks++; if (PC_O !== 32'h0) begin n_fails++; $display("FAIL addi_pc: got %h want 0", PC_O); end
        tick();
        #3;
        n_checks++; if (Valid_O !== 1'b0) begin n_fails++; $display("FAIL addi_drained: got %b want 0", Valid_O); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        tick();
        Done_I = 1'b1; IR_I = 32'h0050_0093; PC_I = 32'h100; Ready_I = 1'b0;
        tick();
        IR_I = 32'h00A0_0113; PC_I = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++; if (Stall_O !== 1'b1) begin n_fails++; $display("FAIL bp_stall[%0d]: got %b want 1", i, Stall_O); end
            n_checks++; if (Valid_O !== 1'b1) begin n_fails++; $display("FAIL bp_valid[%0d]: got %b want 1", i, Valid_O); end
            n_checks++; if (PC_O !== 32'h100 || Imm_O !== 32'd5 || Rd_O !== 5'd1)
                begin n_fails++; $display("FAIL bp_payload[%0d]: got pc=%h imm=%h rd=%0d want 100/5/1", i, PC_O, Imm_O, Rd_O); end
            tick();
        end
        Ready_I = 1'b1;
        #3;
        n_checks++; if (Stall_O !== 1'b0) begin n_fails++; $display("FAIL bp_release_stall: got %b want 0", Stall_O); end
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || PC_O !== 32'h104 || Imm_O !== 32'd10 || Rd_O !== 5'd2)
            begin n_fails++; $display("FAIL bp_second: got v=%b pc=%h imm=%h rd=%0d want 1/104/a/2", Valid_O, PC_O, Imm_O, Rd_O); end
        tick();
        #3;
        n_checks++; if (Valid_O !== 1'b0) begin n_fails++; $display("FAIL bp_drained: got %b want 0", Valid_O); end
    endtask

    task automatic test_hazard();
        do_reset();
        regs[1] = 32'd7;
        tick();
        Done_I = 1'b1; IR_I = 32'h0010_8133; PC_I = 32'h200; Ready_I = 1'b1; Busy_Mask = 32'h2;
        tick();
        Done_I = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++; if (Valid_O !== 1'b0) begin n_fails++; $display("FAIL haz_blocked[%0d]: got %b want 0", i, Valid_O); end
            tick();
        end
        Busy_Mask = 32'h0;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || Op1_O !== 32'd7 || Op2_O !== 32'd7 || Rd_O !== 5'd2)
            begin n_fails++; $display("FAIL haz_release: got v=%b op1=%h op2=%h rd=%0d want 1/7/7/2", Valid_O, Op1_O, Op2_O, Rd_O); end
        tick();
        Done_I = 1'b1; IR_I = 32'h0000_0133; PC_I = 32'h204; Busy_Mask = 32'h1;
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Valid_O !== 1'b1) begin n_fails++; $display("FAIL haz_x0: got %b want 1", Valid_O); end
        tick();
        Busy_Mask = 32'h0;
        regs[1] = 32'h0;
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        Done_I = 1'b1; IR_I = 32'h0000_0463; PC_I = 32'h10; Ready_I = 1'b1;
        tick();
        IR_I = 32'h0050_0093; PC_I = 32'h14;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || Stall_O !== 1'b1 || Imm_O !== 32'd8 || Rd_O !== 5'd0)
            begin n_fails++; $display("FAIL beq_issue: got v=%b st=%b imm=%h rd=%0d want 1/1/8/0", Valid_O, Stall_O, Imm_O, Rd_O); end
        n_checks++; if (Feedback_Branch !== 1'b0) begin n_fails++; $display("FAIL beq_early_fb: got %b want 0", Feedback_Branch); end
        tick();
        #3;
        n_checks++; if (Feedback_Branch !== 1'b1 || next_PC !== 32'h18)
            begin n_fails++; $display("FAIL beq_redirect: got fb=%b npc=%h want 1/18", Feedback_Branch, next_PC); end
        n_checks++; if (Stall_O !== 1'b0 || Valid_O !== 1'b0)
            begin n_fails++; $display("FAIL beq_redir_cycle: got st=%b v=%b want 0/0", Stall_O, Valid_O); end
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Feedback_Branch !== 1'b0 || Valid_O !== 1'b0 || next_PC !== 32'h18)
            begin n_fails++; $display("FAIL beq_dropped: got fb=%b v=%b npc=%h want 0/0/18", Feedback_Branch, Valid_O, next_PC); end
        tick();
        Done_I = 1'b1; IR_I = 32'h0000_1463; PC_I = 32'h20;
        tick();
        IR_I = 32'h0050_0093; PC_I = 32'h24;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || Stall_O !== 1'b1)
            begin n_fails++; $display("FAIL bne_issue: got v=%b st=%b want 1/1", Valid_O, Stall_O); end
        tick();
        #3;
        n_checks++; if (Feedback_Branch !== 1'b0 || Stall_O !== 1'b0 || next_PC !== 32'h18)
            begin n_fails++; $display("FAIL bne_no_pulse: got fb=%b st=%b npc=%h want 0/0/18", Feedback_Branch, Stall_O, next_PC); end
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || PC_O !== 32'h24 || Rd_O !== 5'd1)
            begin n_fails++; $display("FAIL bne_fallthrough: got v=%b pc=%h rd=%0d want 1/24/1", Valid_O, PC_O, Rd_O); end
        tick();
    endtask

    task automatic test_jalr_and_mid_reset();
        do_reset();
        regs[5] = 32'h100;
        tick();
        Done_I = 1'b1; IR_I = 32'h0032_80E7; PC_I = 32'h40; Ready_I = 1'b1;
        tick();
        Done_I = 1'b0;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || Rd_O !== 5'd1 || Imm_O !== 32'd3 || Op1_O !== 32'h100)
            begin n_fails++; $display("FAIL jalr_decode: got v=%b rd=%0d imm=%h op1=%h want 1/1/3/100", Valid_O, Rd_O, Imm_O, Op1_O); end
        tick();
        #3;
        n_checks++; if (Feedback_Branch !== 1'b1 || next_PC !== 32'h102)
            begin n_fails++; $display("FAIL jalr_redirect: got fb=%b npc=%h want 1/102", Feedback_Branch, next_PC); end
        tick();
        Done_I = 1'b1; IR_I = 32'h0050_0093; PC_I = 32'h50; Ready_I = 1'b0;
        #3;
        n_checks++; if (Feedback_Branch !== 1'b0 || next_PC !== 32'h102)
            begin n_fails++; $display("FAIL jalr_hold: got fb=%b npc=%h want 0/102", Feedback_Branch, next_PC); end
        tick();
        IR_I = 32'h00A0_0113; PC_I = 32'h54;
        #3;
        n_checks++; if (Valid_O !== 1'b1 || Stall_O !== 1'b1)
            begin n_fails++; $display("FAIL mid_pre: got v=%b st=%b want 1/1", Valid_O, Stall_O); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (Valid_O !== 1'b0 || Feedback_Branch !== 1'b0 || Stall_O !== 1'b0 || next_PC !== 32'h0 || PC_O !== 32'h0)
            begin n_fails++; $display("FAIL mid_reset: got v=%b fb=%b st=%b npc=%h pc=%h want all 0", Valid_O, Feedback_Branch, Stall_O, next_PC, PC_O); end
        Done_I = 1'b0;
        regs[5] = 32'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [63:0] q [$];
        logic [63:0] head;
        logic [31:0] hir, hpc, cur_ir, cur_pc, exp_npc;
        logic        cur_done, hold, redir, has, exp_valid, exp_issue, exp_accept, exp_stall;
        for (int r = 1; r < 32; r++) regs[r] = 32'($urandom_range(0, 3)) - 32'd2;
        do_reset();
        exp_npc = 32'h0; redir = 1'b0; hold = 1'b0;
        cur_ir = 32'h0; cur_pc = 32'h0; cur_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!hold) begin
                cur_done = ($urandom_range(0, 3) != 0);
                cur_ir   = rand_instr();
                cur_pc   = $urandom & 32'hFFFF_FFFC;
            end
            Done_I = cur_done; IR_I = cur_ir; PC_I = cur_pc;
            Ready_I   = ($urandom_range(0, 3) != 0);
            Busy_Mask = $urandom & $urandom & $urandom;
            #3;
            has = (q.size() != 0);
            head = has ? q[0] : 64'h0;
            hir = head[63:32]; hpc = head[31:0];
            exp_valid  = has && !m_hazard(hir, Busy_Mask);
            exp_issue  = exp_valid && Ready_I;
            exp_accept = Done_I && !redir && (!has || (exp_issue && !m_ctrl(hir)));
            exp_stall  = Done_I && !exp_accept && !redir;
            n_checks++; if (Valid_O !== exp_valid) begin n_fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, Valid_O, exp_valid); end
            n_checks++; if (Stall_O !== exp_stall) begin n_fails++; $display("FAIL rnd_stall c%0d: got %b want %b", c, Stall_O, exp_stall); end
            n_checks++; if (Feedback_Branch !== redir) begin n_fails++; $display("FAIL rnd_fb c%0d: got %b want %b", c, Feedback_Branch, redir); end
            n_checks++; if (next_PC !== exp_npc) begin n_fails++; $display("FAIL rnd_npc c%0d: got %h want %h", c, next_PC, exp_npc); end
            if (has) begin
                n_checks++;
                if (PC_O !== hpc || Imm_O !== m_imm(hir) || Rd_O !== m_rd(hir) || Opcode_O !== hir[6:0] ||
                    Funct3_O !== hir[14:12] || Funct7b5_O !== hir[30] || RF_raddr1 !== hir[19:15] || RF_raddr2 !== hir[24:20] ||
                    Op1_O !== regs[hir[19:15]] || Op2_O !== regs[hir[24:20]]) begin
                    n_fails++;
                    $display("FAIL rnd_payload c%0d ir=%h: got pc=%h imm=%h rd=%0d op=%h want pc=%h imm=%h rd=%0d op=%h",
                             c, hir, PC_O, Imm_O, Rd_O, Opcode_O, hpc, m_imm(hir), m_rd(hir), hir[6:0]);
                end
            end
            redir = 1'b0;
            if (exp_issue) begin
                if (m_ctrl(hir) && m_taken(hir, regs[hir[19:15]], regs[hir[24:20]])) begin
                    redir   = 1'b1;
                    exp_npc = m_target(hir, hpc, regs[hir[19:15]]);
                end
                void'(q.pop_front());
            end
            if (exp_accept) q.push_back({cur_ir, cur_pc});
            hold = exp_stall;
        end
        Done_I = 1'b0; Ready_I = 1'b0; Busy_Mask = '0;
    endtask

    initial begin
        rst = 1'b0; Done_I = 1'b0; Ready_I = 1'b0; Busy_Mask = '0; IR_I = '0; PC_I = '0;
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        test_reset();
        test_addi();
        test_back_pressure();
        test_hazard();
        test_branch();
        test_jalr_and_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stage_id.md
# stage_ID

Instruction decode stage of the RV32I turbo core. It sits directly after `stage_IF`:
- consumes `IR`/`PC`/`Done_O` from IF, and throttles IF through IF's `Feedback_Mem_Acc` input;
- decodes and buffers one instruction, reads the register file and holds it while a source register is busy;
- issues the decoded instruction to EX with a valid/ready handshake;
- resolves branches and jumps, redirecting IF through `next_PC`/`Feedback_Branch`.

## Interface
Parameters: none.
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `IR_I`  in  32  instruction from IF
- `PC_I`  in  32  PC of `IR_I`
- `Done_I`  in  1  IF holds a valid instruction (IF `Done_O`)
- `Stall_O`  out  1  hold IF in its done state (to IF `Feedback_Mem_Acc`)
- `RF_raddr1`, `RF_raddr2`  out  5  rs1/rs2 of the buffered instruction
- `RF_rdata1`, `RF_rdata2`  in  32  combinational register file data
- `Busy_Mask`  in  32  bit i = write to x_i pending downstream; bit 0 ignored
- `Valid_O`  out  1  decoded instruction offered to EX
- `Ready_I`  in  1  EX accepts
- `PC_O`, `Imm_O`  out  32  instruction PC, sign-extended immediate
- `Op1_O`, `Op2_O`  out  32  `RF_rdata1`/`RF_rdata2` pass-through
- `Opcode_O` (7), `Funct3_O` (3), `Funct7b5_O` (1), `Rd_O` (5)  out  decoded fields
- `next_PC`  out  32  registered redirect target
- `Feedback_Branch`  out  1  one-cycle redirect pulse to IF

## Operation
- State machine: EMPTY, FULL, REDIR.
- One-entry buffer holds `IR_I` and `PC_I`. Imm, rd, rs1 and rs2 are decoded combinationally from the buffer.
- Immediate formats: I, S, B, U, J, selected by opcode.
- `Rd_O` is forced to 0 for S/B types and for unknown opcodes. Unknown opcodes otherwise issue as NOPs.
- Source usage:
  - rs1 is used by every type except LUI/AUIPC/JAL.
  - rs2 is used by R, S and B types.
- `hazard` = any used, nonzero source register with its `Busy_Mask` bit set.
- `Valid_O` = (state == FULL) && !hazard.
- `issue` = `Valid_O` && `Ready_I`.
- `ctrl` = buffered opcode is BRANCH, JAL or JALR.
- Taken condition:
  - JAL/JALR are always taken.
  - Branches compare `RF_rdata1`/`RF_rdata2` per funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU; signed compares for BLT/BGE).
- Targets:
  - B-type and JAL: `PC_O` + `Imm_O`.
  - JALR: (`RF_rdata1` + `Imm_O`) & ~1.
  - All arithmetic is 32-bit with wrap-around.
- `accept` = `Done_I` && (state == EMPTY || (state == FULL && issue && !ctrl)).
- `Stall_O` = `Done_I` && !`accept` && state != REDIR.
- Transitions:
  - EMPTY: `accept` → FULL (capture).
  - FULL: no `issue` → stay FULL.
    - `issue` with taken `ctrl` → REDIR, and `next_PC` <= target.
    - `issue` with `accept` → FULL (capture the new instruction).
    - Otherwise → EMPTY.
  - REDIR: unconditionally → EMPTY. Any `Done_I` instruction this cycle is wrong-path and is discarded, not captured. `Stall_O` is 0 so IF leaves its done state on `next_PC`.
- `Feedback_Branch` = (state == REDIR).
- `next_PC` changes only on entry to REDIR and holds its value until the next taken redirect. IF may consume it many cycles later.
- No new instruction is accepted while a `ctrl` instruction is buffered, including its issue cycle.
- Not-taken branches cause no pulse; the fall-through instruction is accepted normally.

## Timing
- Reset (`rst` low, asynchronous, any cycle, mid-operation included):
  - state EMPTY, buffer cleared, `next_PC` = 0;
  - `Valid_O`, `Feedback_Branch`, `Stall_O` = 0, all registered payload = 0.
- Latency: instruction accepted at edge t → `Valid_O` can be high in cycle t+1.
- Throughput is one instruction per cycle without hazards or back-pressure.
- Payload outputs are stable while `Valid_O` && !`Ready_I`.
- `Valid_O` may drop only on a hazard, never on `Ready_I`.
- Taken control transfer issued in cycle t → `Feedback_Branch` = 1 for exactly cycle t+1, with `next_PC` valid from t+1.

## Test plan
- Reset: drive `rst` low mid-FULL → `Valid_O` = 0, `Feedback_Branch` = 0, `next_PC` = 0, `Stall_O` = 0 immediately.
- ADDI x1,x0,5 (0x00500093) at PC 0x0, `Ready_I` = 1 → `Valid_O` next cycle; `Imm_O` = 5, `Rd_O` = 1, `Opcode_O` = 0x13, `PC_O` = 0.
- Back-pressure: hold `Ready_I` = 0 for 3 cycles while a second `Done_I` is pending → `Stall_O` = 1 and payload unchanged; raise `Ready_I` → issue and capture in the same cycle.
- Hazard: `Busy_Mask` = 0x2 with ADD x2,x1,x1 (0x00108133) buffered → `Valid_O` = 0 until the mask clears. `Busy_Mask` = 0x1 never stalls.
- Branches:
  - BEQ x0,x0,+8 (0x00000463) at PC 0x10 → one-cycle `Feedback_Branch`, `next_PC` = 0x18, and the `Done_I` instruction in the pulse cycle is dropped.
  - BNE x0,x0,+8 (0x00001463) → no pulse, and the fall-through instruction is accepted.
- JALR x1,3(x5) (0x003280E7) with `RF_rdata1` = 0x100 → `next_PC` = 0x102, `Rd_O` = 1.
